// File: rtl/tgl_hs_rx_if.sv
// Bundle for the toggle-handshake link and local valid/ready stream of tgl_hs_rx.
// slave = receiver view, master = sender/consumer view.
interface tgl_hs_rx_if #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic              req_tgl;
   logic [DATA_W-1:0] req_data;
   logic              ack_tgl;
   logic              m_valid;
   logic              m_ready;
   logic [DATA_W-1:0] m_data;
   logic [CW-1:0]     count;
   logic              proto_err;

   modport slave (
      input  req_tgl, req_data, m_ready,
      output ack_tgl, m_valid, m_data, count, proto_err
   );

   modport master (
      output req_tgl, req_data, m_ready,
      input  ack_tgl, m_valid, m_data, count, proto_err
   );
endinterface

// File: rtl/tgl_hs_rx.sv
// Two-phase toggle link receiver: captures each req_tgl flip into a FIFO, acks by toggle.
// Define TGL_HS_RX_SYNC_EN to add a two-flop synchronizer on req_tgl.
module tgl_hs_rx #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic       clk,
   input  logic       rst,
   tgl_hs_rx_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

`ifdef TGL_HS_RX_SYNC_EN
   logic              sync1_q, sync1_d;
`endif
   logic              req_s_q, req_s_d;
   logic              req_prev_q, req_prev_d;
   logic              ack_q, ack_d;
   logic              m_valid_q, m_valid_d;
   logic [DATA_W-1:0] m_data_q, m_data_d;
   logic [CW-1:0]     count_q, count_d;
   logic              proto_err_q, proto_err_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];

   logic det, pop, space, capture;

   always_comb begin
`ifdef TGL_HS_RX_SYNC_EN
      sync1_d = bus.req_tgl;
      req_s_d = sync1_q;
`else
      req_s_d = bus.req_tgl;
`endif
      det     = req_s_q ^ req_prev_q;
      pop     = m_valid_q & bus.m_ready;
      // A full FIFO still has room when the head leaves at the same edge.
      space   = (count_q != FULL_C) | pop;
      capture = det & space;

      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      req_prev_d = req_prev_q;
      ack_d      = ack_q;
      count_d    = count_q;

      if (capture) begin
         mem_d[wr_ptr_q] = bus.req_data;
         wr_ptr_d        = wr_ptr_q + PW'(1);
         req_prev_d      = req_s_q;
         ack_d           = ~ack_q;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({capture, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      // Stalled toggle undone by the sender before it could be captured.
      proto_err_d = proto_err_q | (det & ~space & (req_s_d == req_prev_q));

      m_valid_d = (count_d != '0);
      m_data_d  = m_data_q;
      if (count_d != '0) begin
         // Bypass the incoming word when it lands directly at the new head slot.
         if (capture && (wr_ptr_q == rd_ptr_d)) begin
            m_data_d = bus.req_data;
         end else begin
            m_data_d = mem_q[rd_ptr_d];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
`ifdef TGL_HS_RX_SYNC_EN
         sync1_q     <= 1'b0;
`endif
         req_s_q     <= 1'b0;
         req_prev_q  <= 1'b0;
         ack_q       <= 1'b0;
         m_valid_q   <= 1'b0;
         m_data_q    <= '0;
         count_q     <= '0;
         proto_err_q <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         mem_q       <= '{default: '0};
      end else begin
`ifdef TGL_HS_RX_SYNC_EN
         sync1_q     <= sync1_d;
`endif
         req_s_q     <= req_s_d;
         req_prev_q  <= req_prev_d;
         ack_q       <= ack_d;
         m_valid_q   <= m_valid_d;
         m_data_q    <= m_data_d;
         count_q     <= count_d;
         proto_err_q <= proto_err_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         mem_q       <= mem_d;
      end
   end

   assign bus.ack_tgl   = ack_q;
   assign bus.m_valid   = m_valid_q;
   assign bus.m_data    = m_data_q;
   assign bus.count     = count_q;
   assign bus.proto_err = proto_err_q;

endmodule

// File: tb/tb_tgl_hs_rx.sv
// Bench for tgl_hs_rx: directed test-plan steps plus a random phase, checked every
// cycle against a queue-based reference model of the link and FIFO.
module tb_tgl_hs_rx;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 4;
`ifdef TGL_HS_RX_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   tgl_hs_rx_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();
   tgl_hs_rx #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

   // Reference model state
   logic [7:0] exp_q [$];
   bit         pend;
   int         age;
   logic [7:0] pend_word;
   bit         col_active;
   int         col_age;
   logic       exp_ack;
   logic       exp_err;
   bit         was_reset;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Advance one clock: predict the edge from the model, then compare at the negedge.
   task automatic cycle();
      bit pop, cap, elig;
      was_reset = 1'b0;
      if (rst) begin
         exp_q.delete();
         exp_ack    = 1'b0;
         exp_err    = 1'b0;
         pend       = 1'b0;
         col_active = 1'b0;
         was_reset  = 1'b1;
      end else begin
         pop  = bus.m_ready && (exp_q.size() != 0);
         elig = pend && (age >= LAT);
         cap  = elig && ((exp_q.size() < DEPTH) || pop);
         if (col_active && !cap) begin
            if (col_age == LAT - 1) begin
               exp_err    = 1'b1;
               pend       = 1'b0;
               col_active = 1'b0;
            end else begin
               col_age++;
            end
         end
         if (pop) void'(exp_q.pop_front());
         if (cap) begin
            exp_q.push_back(pend_word);
            exp_ack = ~exp_ack;
            pend    = 1'b0;
         end else if (pend) begin
            age++;
         end
      end
      @(posedge clk);
      @(negedge clk);
      chk("count", 32'(bus.count), 32'(exp_q.size()));
      chk("m_valid", 32'(bus.m_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) chk("m_data", 32'(bus.m_data), 32'(exp_q[0]));
      if (was_reset) chk("m_data_rst", 32'(bus.m_data), 32'(0));
      chk("ack_tgl", 32'(bus.ack_tgl), 32'(exp_ack));
      chk("proto_err", 32'(bus.proto_err), 32'(exp_err));
   endtask

   task automatic flip(input logic [7:0] w);
      bus.req_data = w;
      bus.req_tgl  = ~bus.req_tgl;
      pend         = 1'b1;
      age          = 0;
      pend_word    = w;
   endtask

   // Wait (bounded) for the previous word to be acknowledged, then send the next.
   task automatic send(input logic [7:0] w);
      int n;
      n = 0;
      while (pend && n < 50) begin
         cycle();
         n++;
      end
      checks++;
      assert (!pend) else begin
         errors++;
         $error("FAIL send_timeout: observed=pending expected=acked word=%0h", pend_word);
      end
      flip(w);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      bus.req_tgl  = 1'b0;
      bus.req_data = '0;
      bus.m_ready  = 1'b0;
      pend = 1'b0; col_active = 1'b0; exp_ack = 1'b0; exp_err = 1'b0;
      @(negedge clk);
      run(2);
      rst = 1'b0;
      run(1);

      // Single word with consumer ready
      bus.m_ready = 1'b1;
      send(8'hA5);
      run(5);

      // Fill to full, fifth word stalls, captured on first pop
      bus.m_ready = 1'b0;
      for (int i = 1; i <= 5; i++) send(8'(i));
      run(4);
      bus.m_ready = 1'b1;
      run(8);

      // Wrap: ten streamed words
      for (int i = 0; i < 10; i++) send(8'(8'h10 + i));
      run(5);

      // Consumer stall with two words held
      bus.m_ready = 1'b0;
      send(8'h21);
      send(8'h22);
      run(LAT + 1);
      run(3);
      bus.m_ready = 1'b1;
      run(4);

      // Protocol error: full FIFO, request toggled twice without a pop
      bus.m_ready = 1'b0;
      for (int i = 0; i < 5; i++) send(8'(8'h30 + i));
      run(3);
      bus.req_tgl = ~bus.req_tgl;
      col_active  = 1'b1;
      col_age     = 0;
      run(5);
      bus.m_ready = 1'b1;
      run(1);
      bus.m_ready = 1'b0;
      run(2);

      // Mid-transfer reset with three words held
      rst = 1'b1;
      bus.req_tgl = 1'b0;
      run(1);
      rst = 1'b0;
      bus.m_ready = 1'b1;
      send(8'h3C);
      run(5);

      // Random traffic with varying consumer pressure
      for (int i = 0; i < 400; i++) begin
         if (i < 150)      bus.m_ready = ($urandom_range(0, 3) != 0);
         else if (i < 300) bus.m_ready = ($urandom_range(0, 3) == 0);
         else              bus.m_ready = 1'b1;
         if (!pend && ($urandom_range(0, 1) == 1)) flip(8'($urandom));
         cycle();
      end
      run(10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/tgl_hs_rx.md
# tgl_hs_rx

Receiving end of the team's two-phase (toggle) request/acknowledge link. A sender flips `req_tgl` once per word while holding `req_data` stable. This block detects each toggle, captures the word into a small FIFO and returns one `ack_tgl` flip per captured word, using the same toggle-register behaviour as the link's sender side. Buffered words go out on a valid/ready stream to local logic.

## Interface
Parameters:
- `DATA_W`, 8, width of `req_data` / `m_data`
- `DEPTH`, 4, FIFO entries; power of two, ≥2

Ports:
- `clk` input 1, single clock; all logic on rising edge
- `rst` input 1, reset; synchronous, active-high
- `req_tgl` input 1, request toggle; each level change = one new word
- `req_data` input DATA_W, word; stable from the `req_tgl` flip until the matching `ack_tgl` flip
- `ack_tgl` output 1, acknowledge toggle; flips once per captured word
- `m_valid` output 1, FIFO non-empty
- `m_ready` input 1, consumer accepts head word when high with `m_valid`
- `m_data` output DATA_W, FIFO head word
- `count` output $clog2(DEPTH)+1, entries held, 0..DEPTH
- `proto_err` output 1, sticky: a request toggle was lost

## Operation
- Input path: `req_tgl` passes through the sample stage (see Configuration) to give `req_s`. Register `req_prev` holds the last accepted level.
- Detect: `det = req_s ^ req_prev`, combinational.
- Capture at an edge where `det` is 1 and the FIFO has space:
  - write `req_data` at the write pointer
  - `req_prev <= req_s`
  - `ack_tgl <= ~ack_tgl`
- Space means `count < DEPTH`, or `count == DEPTH` with a pop in the same cycle (simultaneous pop and capture when full is allowed; `count` stays at DEPTH).
- Back-pressure: while `det` is 1 and there is no space, nothing changes on the input side. `ack_tgl` is withheld, so the sender stalls. No data is lost.
- Pop at an edge where `m_valid && m_ready`: advance the read pointer.
- `count` update: +1 on capture only, −1 on pop only, unchanged when both or neither occur.
- `m_data` is the registered FIFO head. It is valid whenever `m_valid` is 1 and holds its value while `m_ready` is 0.
- Pointers are `$clog2(DEPTH)` bits wide and wrap modulo DEPTH.
- Protocol error: while a capture is pending (`det` 1, no space), if `req_s` changes so that `req_s == req_prev`, a toggle pair has collapsed.
  - Set `proto_err <= 1`; it is cleared only by `rst`.
  - `det` drops to 0 and no word is captured for that pair.
- Reset (at any time, including mid-transfer) sets:
  - `ack_tgl` = 0, `m_valid` = 0, `m_data` = 0, `count` = 0, `proto_err` = 0
  - pointers = 0, `req_prev` = 0, sample registers = 0
  - Buffered words are discarded. The sender must be reset in the same cycle so that `req_tgl` = 0.

## Timing
- Edge E0 is the first rising edge at which a new `req_tgl` level is sampled.
- Without sync (FIFO has space): `req_s` updates at E0, capture at E0+1. After E0+1, `ack_tgl` has flipped, `m_valid` = 1 and `m_data` = word.
- With sync: one extra cycle; capture at E0+2.
- Pop-to-capture throughput: 1 word/cycle on the FIFO side. Link throughput is limited by the sender's round trip.
- When full, capture happens at the same edge as the first pop.
- `m_valid` deasserts at the edge that pops the last entry with no simultaneous capture.

## Configuration
- Macro: `TGL_HS_RX_SYNC_EN`.
- Defined: `req_tgl` passes through a two-flop synchronizer before `req_s`, so capture latency is E0+2. For senders on an unrelated clock; `req_data` must meet the stability rule above.
- Undefined: `req_tgl` is registered once (`req_s`), so capture latency is E0+1. Same-clock senders only.
- Handshake semantics, reset values and `proto_err` are identical in both builds.

## Test plan
- Reset, then one word: `req_data`=0xA5, flip `req_tgl` 0→1 with `m_ready`=1. Expect:
  - `ack_tgl` goes 0→1 at E0+1 (E0+2 with sync)
  - `m_valid` high for one cycle with `m_data`=0xA5
  - `count` returns to 0
- Fill to full with `m_ready`=0: send 0x01..0x05 with DEPTH=4. Expect:
  - 4 acks, `count`=4
  - the fifth toggle gets no ack while `m_ready`=0
  - on the first pop (`m_data`=0x01), 0x05 is captured at the same edge, `count` stays 4 and `ack_tgl` flips
  - drain order is 0x02, 0x03, 0x04, 0x05
- Wrap: stream 10 words 0x10..0x19 with `m_ready`=1. Expect output in order, pointers wrapping twice, `proto_err`=0.
- Consumer stall: `m_ready` low for 3 cycles with 2 words held. Expect `m_data` stable at the first word and `count`=2 throughout.
- Protocol error: fill to full, then flip `req_tgl` twice without a pop. Expect `proto_err`=1 sticky, `count`=4 unchanged, `ack_tgl` unchanged.
- Mid-transfer reset: assert `rst` for 1 cycle with `count`=3. Expect all outputs 0 the next cycle; a new word 0x3C afterwards is captured normally.
